// File: rtl/alu_div_pkg.sv
// Shared types, saturation limits and the saturation helper for alu_div.
// Optional feature macro used by the divider: ALU_DIV_REM_EN (remainder output).
package alu_div_pkg;

  localparam int DIV_N    = 8;
  localparam int DIV_FRAC = 7;
  localparam int DIV_QW   = DIV_N + DIV_FRAC;

  // Signed Q1.7 limits expressed as raw n-bit patterns.
  localparam logic [DIV_N-1:0] SAT_MAX = {1'b0, {(DIV_N-1){1'b1}}};
  localparam logic [DIV_N-1:0] SAT_MIN = {1'b1, {(DIV_N-1){1'b0}}};

  // The same limits widened to the unsigned quotient magnitude width.
  localparam logic [DIV_QW-1:0] Q_POS_LIM = {{DIV_FRAC{1'b0}}, SAT_MAX};
  localparam logic [DIV_QW-1:0] Q_NEG_LIM = {{DIV_FRAC{1'b0}}, SAT_MIN};

  typedef enum logic [1:0] {IDLE, RUN, FIX} div_state_t;

  // Clamp an unsigned quotient magnitude into the signed range, then apply the sign.
  function automatic logic [DIV_N-1:0] sat_q(input logic [DIV_QW-1:0] q, input logic sgn);
    logic [DIV_N-1:0] mag;
    mag = q[DIV_N-1:0];
    if (!sgn) return (q > Q_POS_LIM) ? SAT_MAX : mag;
    else      return (q > Q_NEG_LIM) ? SAT_MIN : -mag;
  endfunction

endpackage

// File: rtl/alu_div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
  parameter int n = 8
) (
  input  logic [n-1:0] rem_in,
  input  logic         dbit,
  input  logic [n-1:0] divisor,
  output logic [n-1:0] rem_out,
  output logic         q
);

  logic [n:0] shifted;
  logic [n:0] diff;

  // The remainder stays below the divisor, so one extra bit covers the shift.
  always_comb begin
    shifted = {rem_in, dbit};
    diff    = shifted - {1'b0, divisor};
    q       = (shifted >= {1'b0, divisor});
    rem_out = q ? diff[n-1:0] : shifted[n-1:0];
  end

endmodule

// File: rtl/alu_div.sv
// Sequential signed fractional divider: result = (a << FRAC) / b in Q1.7,
// truncated toward zero and saturated. Fixed latency of n+FRAC+1 edges.
// Optional feature: define ALU_DIV_REM_EN to add the signed remainder port rem.
//
// Handshake: start is sampled only while idle and not in the done cycle; once
// accepted, busy is high for the n+FRAC RUN cycles, then done pulses for one
// cycle with result/divzero (and rem) valid and held until the next accepted start.
module alu_div
  import alu_div_pkg::*;
#(
  parameter int n    = DIV_N,
  parameter int FRAC = DIV_FRAC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] result,
  output logic         divzero
`ifdef ALU_DIV_REM_EN
  ,
  output logic [n-1:0] rem
`endif
);

  localparam int QW = n + FRAC;
  localparam int CW = $clog2(QW + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(QW);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  div_state_t   state;
  logic [CW-1:0] cnt;
  logic [QW-1:0] dvd;
  logic [QW-1:0] quo;
  logic [n-1:0]  divisor;
  logic [n-1:0]  prem;
  logic          sgn;
  logic          a_neg;
  logic          dz;

  logic [n-1:0]  a_mag;
  logic [n-1:0]  b_mag;
  logic [n-1:0]  step_rem;
  logic          step_q;

  // Operand magnitudes as n-bit unsigned values (-128 maps to 128).
  always_comb begin
    a_mag = a[n-1] ? -a : a;
    b_mag = b[n-1] ? -b : b;
  end

  div_step #(.n(n)) u_step (
    .rem_in  (prem),
    .dbit    (dvd[QW-1]),
    .divisor (divisor),
    .rem_out (step_rem),
    .q       (step_q)
  );

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      dvd     <= '0;
      quo     <= '0;
      divisor <= '0;
      prem    <= '0;
      sgn     <= 1'b0;
      a_neg   <= 1'b0;
      dz      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      divzero <= 1'b0;
`ifdef ALU_DIV_REM_EN
      rem     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // The done cycle still belongs to the finished operation.
          if (start && !done) begin
            dvd     <= {a_mag, {FRAC{1'b0}}};
            divisor <= b_mag;
            prem    <= '0;
            quo     <= '0;
            sgn     <= a[n-1] ^ b[n-1];
            a_neg   <= a[n-1];
            dz      <= (b == '0);
            cnt     <= CNT_INIT;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          dvd  <= {dvd[QW-2:0], 1'b0};
          prem <= step_rem;
          quo  <= {quo[QW-2:0], step_q};
          cnt  <= cnt - 1'b1;
          if (cnt == CNT_LAST) begin
            busy  <= 1'b0;
            state <= FIX;
          end
        end
        FIX: begin
          done    <= 1'b1;
          divzero <= dz;
          result  <= dz ? (a_neg ? SAT_MIN : SAT_MAX) : sat_q(quo, sgn);
`ifdef ALU_DIV_REM_EN
          rem     <= dz ? '0 : (a_neg ? -prem : prem);
`endif
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div.sv
// Testbench for alu_div: directed cases, protocol cases and random operands
// checked against a signed-arithmetic reference model.
module tb_alu_div;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       divzero;
`ifdef ALU_DIV_REM_EN
  logic [7:0] rem;
`endif

  int checks = 0;
  int fails  = 0;

  alu_div dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .divzero (divzero)
`ifdef ALU_DIV_REM_EN
    ,
    .rem     (rem)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed integer division of a*2^7 by b, truncating, then clamped.
  function automatic void model(input logic [7:0] va, input logic [7:0] vb,
                                output logic [7:0] er, output logic edz,
                                output logic [7:0] erm);
    int sa;
    int sb;
    int num;
    int q;
    int r;
    sa = int'($signed(va));
    sb = int'($signed(vb));
    if (sb == 0) begin
      edz = 1'b1;
      er  = (sa < 0) ? 8'h80 : 8'h7F;
      erm = 8'h00;
    end else begin
      edz = 1'b0;
      num = sa * 128;
      q   = num / sb;
      r   = num % sb;
      if (q > 127)       er = 8'h7F;
      else if (q < -128) er = 8'h80;
      else               er = 8'(q);
      erm = 8'(r);
    end
  endfunction

  // Drive a start request; it is sampled at the next rising edge.
  task automatic launch(input logic [7:0] va, input logic [7:0] vb, input bit hold);
    a = va;
    b = vb;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Wait (bounded) for done and check timing and outputs of the accepted operation.
  task automatic finish_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                           input bit hold, input bit leave, output logic [7:0] got);
    logic [7:0] er;
    logic [7:0] erm;
    logic       edz;
    int         edges;
    int         bcnt;
    model(va, vb, er, edz, erm);
    edges = 0;
    bcnt  = 0;
    while (done !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk);
      #1;
      edges++;
      if (hold) begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
    end
    start = 1'b0;
    chk({tag, " latency"}, 16'(edges), 16'd16);
    chk({tag, " busy_cycles"}, 16'(bcnt), 16'd15);
    chk({tag, " busy_at_done"}, 16'(busy), 16'd0);
    chk({tag, " result"}, 16'(result), 16'(er));
    chk({tag, " divzero"}, 16'(divzero), 16'(edz));
`ifdef ALU_DIV_REM_EN
    chk({tag, " rem"}, 16'(rem), 16'(erm));
`endif
    got = result;
    if (leave) begin
      @(posedge clk);
      #1;
      chk({tag, " done_pulse"}, 16'(done), 16'd0);
      chk({tag, " idle_after"}, 16'(busy), 16'd0);
    end
  endtask

  logic [7:0] ta [9] = '{8'h40, 8'hC0, 8'h40, 8'hC0, 8'h60, 8'hA0, 8'h80, 8'h10, 8'h80};
  logic [7:0] tb [9] = '{8'h60, 8'h60, 8'hA0, 8'hA0, 8'h20, 8'h20, 8'h80, 8'h00, 8'h00};
  logic [7:0] tr [9] = '{8'h55, 8'hAB, 8'hAB, 8'h55, 8'h7F, 8'h80, 8'h7F, 8'h7F, 8'h80};

  initial begin
    logic [7:0] got;
    logic [7:0] ra;
    logic [7:0] rb;
    int         dcount;

    // Reset
    reset = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    #12;
    chk("reset busy", 16'(busy), 16'd0);
    chk("reset done", 16'(done), 16'd0);
    chk("reset result", 16'(result), 16'd0);
    chk("reset divzero", 16'(divzero), 16'd0);
`ifdef ALU_DIV_REM_EN
    chk("reset rem", 16'(rem), 16'd0);
`endif
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed operand table: signs, saturation, divide by zero
    for (int i = 0; i < 9; i++) begin
      launch(ta[i], tb[i], 1'b0);
      finish_op($sformatf("dir%0d", i), ta[i], tb[i], 1'b0, 1'b1, got);
      chk($sformatf("dir%0d table", i), 16'(got), 16'(tr[i]));
    end

    // start held high for the whole operation with changing operands
    launch(8'h40, 8'h60, 1'b1);
    finish_op("hold", 8'h40, 8'h60, 1'b1, 1'b1, got);

    // start raised in the done cycle is ignored, then accepted next cycle
    launch(8'hC0, 8'hA0, 1'b0);
    finish_op("pre_done", 8'hC0, 8'hA0, 1'b0, 1'b0, got);
    a = 8'h60;
    b = 8'h20;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("done_cycle_start_ignored", 16'(busy), 16'd0);
    launch(8'h60, 8'h20, 1'b0);
    finish_op("after_done", 8'h60, 8'h20, 1'b0, 1'b1, got);

    // Reset in the middle of an operation
    launch(8'h40, 8'h60, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset busy", 16'(busy), 16'd0);
    chk("midreset done", 16'(done), 16'd0);
    chk("midreset result", 16'(result), 16'd0);
    chk("midreset divzero", 16'(divzero), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dcount++;
    end
    chk("midreset no_done", 16'(dcount), 16'd0);
    launch(8'hC0, 8'h60, 1'b0);
    finish_op("post_reset", 8'hC0, 8'h60, 1'b0, 1'b1, got);

    // Random operands, with a forced zero divisor now and then
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 8 == 7) ? 8'h00 : 8'($urandom_range(0, 255));
      launch(ra, rb, 1'b0);
      finish_op($sformatf("rnd%0d a=%0h b=%0h", i, ra, rb), ra, rb, 1'b0, 1'b1, got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
